// File: rtl/leaky_relu_backward.sv
`default_nettype none
// ============================================================================
// leaky_relu_backward : sign-mask FIFO gating upstream gradients by 1 or 13/64
// Revision 1.0
// ============================================================================
module leaky_relu_backward #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mask_clr,
   input  logic                         fwd_valid,
   input  logic signed [DATA_WIDTH-1:0] fwd_data,
   input  logic                         grad_valid,
   input  logic signed [DATA_WIDTH-1:0] grad_in,
   output logic                         grad_ready,
   output logic                         grad_out_valid,
   output logic signed [DATA_WIDTH-1:0] grad_out,
   output logic [ADDR_WIDTH:0]          mask_count,
   output logic                         mask_full,
   output logic                         mask_empty,
   output logic                         overflow_err,
   output logic                         underflow_err
);

   localparam logic [ADDR_WIDTH:0]          C_FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]          C_CNT_ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0]        C_PTR_ONE    = ADDR_WIDTH'(1);
   localparam logic signed [DATA_WIDTH-1:0] C_ZERO       = '0;

   logic                         mask_mem [DEPTH];

   logic [ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]        rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]          count_q, count_d;
   logic                         ovf_q, ovf_d;
   logic                         udf_q, udf_d;
   logic                         out_valid_q, out_valid_d;
   logic signed [DATA_WIDTH-1:0] out_q, out_d;

   logic                         empty, full, push, pop, rd_mask, fwd_neg;
   logic signed [DATA_WIDTH-1:0] scaled;

   assign empty   = (count_q == '0);
   assign full    = (count_q == C_FULL_COUNT);
   assign fwd_neg = (fwd_data < C_ZERO);
   assign pop     = grad_valid && !empty;
   // A pop frees a slot this cycle, so a full FIFO still accepts the push.
   assign push    = fwd_valid && (!full || pop) && !mask_clr;
   assign rd_mask = mask_mem[rd_ptr_q];
   assign scaled  = (grad_in >>> 3) + (grad_in >>> 4) + (grad_in >>> 6);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      udf_d       = udf_q;
      out_valid_d = pop;
      out_d       = out_q;

      if (push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;

      case ({push, pop})
         2'b10:   count_d = count_q + C_CNT_ONE;
         2'b01:   count_d = count_q - C_CNT_ONE;
         default: count_d = count_q;
      endcase

      if (fwd_valid && full && !pop) ovf_d = 1'b1;
      if (grad_valid && empty)       udf_d = 1'b1;

      if (pop) out_d = rd_mask ? scaled : grad_in;

      // Flush resets bookkeeping only; a pop issued alongside still delivers.
      if (mask_clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mask_mem[wr_ptr_q] <= fwd_neg;
   end

   assign grad_ready     = !empty;
   assign grad_out_valid = out_valid_q;
   assign grad_out       = out_q;
   assign mask_count     = count_q;
   assign mask_full      = full;
   assign mask_empty     = empty;
   assign overflow_err   = ovf_q;
   assign underflow_err  = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_leaky_relu_backward.sv
`default_nettype none
// ============================================================================
// tb_leaky_relu_backward : directed self-checking bench for leaky_relu_backward
// Revision 1.0
// ============================================================================
module tb_leaky_relu_backward;

   localparam int DW    = 16;
   localparam int DEPTH = 256;
   localparam int AW    = 8;

   logic                 clk = 1'b0;
   logic                 rst, mask_clr, fwd_valid, grad_valid;
   logic signed [DW-1:0] fwd_data, grad_in;
   logic                 grad_ready, grad_out_valid, mask_full, mask_empty;
   logic                 overflow_err, underflow_err;
   logic signed [DW-1:0] grad_out;
   logic [AW:0]          mask_count;

   int n_checks = 0;
   int n_errors = 0;
   bit mask_model [$];

   always #5 clk = ~clk;

   leaky_relu_backward #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .mask_clr       (mask_clr),
      .fwd_valid      (fwd_valid),
      .fwd_data       (fwd_data),
      .grad_valid     (grad_valid),
      .grad_in        (grad_in),
      .grad_ready     (grad_ready),
      .grad_out_valid (grad_out_valid),
      .grad_out       (grad_out),
      .mask_count     (mask_count),
      .mask_full      (mask_full),
      .mask_empty     (mask_empty),
      .overflow_err   (overflow_err),
      .underflow_err  (underflow_err)
   );

   task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int d);
      fwd_valid = 1'b1;
      fwd_data  = DW'(d);
      step();
      fwd_valid = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input int g, input int exp);
      grad_valid = 1'b1;
      grad_in    = DW'(g);
      step();
      grad_valid = 1'b0;
      chk({tag, "_valid"}, grad_out_valid, 1);
      chk({tag, "_data"}, grad_out, exp);
   endtask

   // Floor division by a power of two, built from truncating division.
   function automatic int floor_div(int g, int d);
      int q;
      q = g / d;
      if ((g % d) != 0 && g < 0) q = q - 1;
      return q;
   endfunction

   function automatic int model(int g, bit m);
      return m ? floor_div(g, 8) + floor_div(g, 16) + floor_div(g, 64) : g;
   endfunction

   initial begin
      rst = 1'b1; mask_clr = 1'b0; fwd_valid = 1'b0; grad_valid = 1'b0;
      fwd_data = '0; grad_in = '0;
      step(); step();
      rst = 1'b0;

      chk("rst_count", mask_count, 0);
      chk("rst_empty", mask_empty, 1);
      chk("rst_full", mask_full, 0);
      chk("rst_ready", grad_ready, 0);
      chk("rst_ovalid", grad_out_valid, 0);
      chk("rst_out", grad_out, 0);
      chk("rst_ovf", overflow_err, 0);
      chk("rst_udf", underflow_err, 0);

      // Basic sign gating, zero passes unchanged.
      push(5); push(-3); push(0);
      chk("basic_count", mask_count, 3);
      chk("basic_ready", grad_ready, 1);
      pop_chk("basic0", 100, 100);
      pop_chk("basic1", 100, 19);
      pop_chk("basic2", 100, 100);
      chk("basic_empty", mask_empty, 1);
      step();
      chk("idle_ovalid", grad_out_valid, 0);
      chk("idle_hold", grad_out, 100);

      // Floor rounding on negative gradients.
      push(-1); pop_chk("neg100", -100, -22);
      push(-1); pop_chk("neg64", -64, -13);
      push(-7); pop_chk("neg1", -1, -3);
      push(7);  pop_chk("pos_mask_neg_grad", -100, -100);

      // Fill to capacity, then one push too many.
      fwd_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_data = (i % 3 == 0) ? -16'sd1 : 16'sd1;
         step();
      end
      chk("fill_full", mask_full, 1);
      fwd_data = 16'sd9;
      step();
      chk("ovf_count", mask_count, 256);
      chk("ovf_flag", overflow_err, 1);
      chk("ovf_full", mask_full, 1);
      grad_valid = 1'b1;
      grad_in    = 16'sd64;
      step();
      fwd_valid = 1'b0; grad_valid = 1'b0;
      chk("full_pp_count", mask_count, 256);
      chk("full_pp_ovf", overflow_err, 1);
      chk("full_pp_valid", grad_out_valid, 1);
      chk("full_pp_data", grad_out, 13);
      mask_clr = 1'b1; step(); mask_clr = 1'b0;
      chk("clr_count", mask_count, 0);
      chk("clr_ovf", overflow_err, 0);

      // Gradient on empty FIFO with a simultaneous push.
      fwd_valid = 1'b1; fwd_data = -16'sd5;
      grad_valid = 1'b1; grad_in = 16'sd50;
      step();
      fwd_valid = 1'b0; grad_valid = 1'b0;
      chk("udf_ovalid", grad_out_valid, 0);
      chk("udf_flag", underflow_err, 1);
      chk("udf_count", mask_count, 1);
      pop_chk("udf_after", 50, 9);

      // Flush with entries and a sticky error present.
      push(1); push(-2); push(3); push(-4);
      chk("pre_clr_count", mask_count, 4);
      mask_clr = 1'b1; step(); mask_clr = 1'b0;
      chk("clr4_count", mask_count, 0);
      chk("clr4_udf", underflow_err, 0);
      chk("clr4_ovf", overflow_err, 0);
      chk("clr4_ready", grad_ready, 0);

      // Flush alongside a pop: pop completes, push discarded.
      push(-2);
      mask_clr = 1'b1; fwd_valid = 1'b1; fwd_data = -16'sd3;
      grad_valid = 1'b1; grad_in = 16'sd64;
      step();
      mask_clr = 1'b0; fwd_valid = 1'b0; grad_valid = 1'b0;
      chk("clrpop_valid", grad_out_valid, 1);
      chk("clrpop_data", grad_out, 13);
      chk("clrpop_count", mask_count, 0);

      // Streaming through the pointer wrap, pops trailing pushes by 10.
      for (int t = 0; t < 310; t++) begin
         int g, e;
         bit m, do_pop;
         fwd_valid = (t < 300);
         fwd_data  = (t % 2 == 1) ? DW'(-(t + 1)) : DW'(t);
         if (t < 300) mask_model.push_back(t % 2 == 1);
         do_pop = (t >= 10);
         g = ((t * 37) % 2001) - 1000;
         grad_valid = do_pop;
         grad_in    = DW'(g);
         e = 0;
         if (do_pop) begin
            m = mask_model.pop_front();
            e = model(g, m);
         end
         step();
         if (do_pop) begin
            chk($sformatf("wrap_valid_%0d", t), grad_out_valid, 1);
            chk($sformatf("wrap_data_%0d", t), grad_out, e);
         end
         if (t == 150) chk("wrap_mid_count", mask_count, 10);
      end
      fwd_valid = 1'b0; grad_valid = 1'b0;
      chk("wrap_end_count", mask_count, 0);
      chk("wrap_end_ovf", overflow_err, 0);
      chk("wrap_end_udf", underflow_err, 0);

      // Reset in the middle of a pop stream.
      push(-1); push(2); push(-3);
      grad_valid = 1'b1; grad_in = 16'sd64;
      step();
      chk("stream_valid", grad_out_valid, 1);
      chk("stream_data", grad_out, 13);
      rst = 1'b1;
      step();
      rst = 1'b0; grad_valid = 1'b0;
      chk("midrst_valid", grad_out_valid, 0);
      chk("midrst_out", grad_out, 0);
      chk("midrst_count", mask_count, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
